// File: rtl/sbc_unit_pkg.sv
// sbc_unit_pkg: shared FSM encoding, BCD correction constants and flag packing for sbc_unit
package sbc_unit_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;
    localparam logic [9:0] NIB_ADJ  = 10'd6;
    localparam logic [9:0] BYTE_ADJ = 10'h060;
    localparam int FLAG_N = 7;
    localparam int FLAG_V = 6;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    // Places N/V/Z/C at their P-register positions; other bits stay 0.
    function automatic logic [7:0] pack_flags(input logic n, input logic v, input logic z, input logic c);
        logic [7:0] p;
        p = '0;
        p[FLAG_N] = n;
        p[FLAG_V] = v;
        p[FLAG_Z] = z;
        p[FLAG_C] = c;
        return p;
    endfunction

    function automatic logic flag_of(input logic [7:0] p, input int idx);
        return p[idx[2:0]];
    endfunction
endpackage

// File: rtl/CLA_8bit.sv
// CLA_8bit: 8-bit adder, sum/cout = a + b + cin, generate/propagate carry chain
//   a, b : addends   cin : carry in   sum : 8-bit sum   cout : carry out
module CLA_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] g, p;
    logic       cy;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        cy = cin;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = p[i] ^ cy;
            cy     = g[i] | (p[i] & cy);
        end
        cout = cy;
    end
endmodule

// File: rtl/sbc_nibble_adj.sv
// sbc_nibble_adj: signed low-nibble subtract with NMOS decimal borrow correction
//   a, m : low nibbles of the operands   c : carry in (1 = no borrow)
//   al   : 10-bit signed corrected low partial
module sbc_nibble_adj
    import sbc_unit_pkg::*;
(
    input  logic [3:0]        a,
    input  logic [3:0]        m,
    input  logic              c,
    output logic signed [9:0] al
);
    logic signed [9:0] raw, adj;

    always_comb begin
        raw = $signed({6'd0, a}) - $signed({6'd0, m}) + $signed({9'd0, c}) - 10'sd1;
        adj = raw - $signed(NIB_ADJ);
        // A negative partial borrows: keep the corrected digit, carry -0x10 into the high nibble.
        al  = raw[9] ? ($signed({6'd0, adj[3:0]}) - 10'sd16) : raw;
    end
endmodule

// File: rtl/sbc_unit.sv
// sbc_unit: multi-cycle 6502 SBC unit, A - M - (1 - C) in binary or NMOS decimal mode
//   clk, rst : clock, synchronous active-high reset
//   start    : request, sampled only when idle; a, m, c_in, d_flag latched then
//   busy     : operation in flight   done : one-cycle result-valid pulse
//   result, c_out, v_out, z_out, n_out : difference and flags, held until next update
module sbc_unit
    import sbc_unit_pkg::*;
#(
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] m,
    input  logic       c_in,
    input  logic       d_flag,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       c_out,
    output logic       v_out,
    output logic       z_out,
    output logic       n_out
);
    state_t            state, state_nx;
    logic [7:0]        a_r, m_r, sum, p_r, res_nx;
    logic              c_r, dec_r, cout, v_nx;
    logic signed [9:0] al, al_r, t, t_adj;

    sbc_nibble_adj u_nib (
        .a  (a_r[3:0]),
        .m  (m_r[3:0]),
        .c  (c_r),
        .al (al)
    );

    // Binary difference as a + ~m + c on the shared carry chain.
    CLA_8bit u_cla (
        .a    (a_r),
        .b    (~m_r),
        .cin  (c_r),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        state_nx = (state == IDLE) ? (start ? LO : IDLE) : state_t'(state + 2'd1);
        busy     = state != IDLE;
        done     = state == DONE;
        t        = $signed({2'b00, a_r & 8'hF0}) - $signed({2'b00, m_r & 8'hF0}) + al_r;
        t_adj    = t[9] ? t - $signed(BYTE_ADJ) : t;
        res_nx   = dec_r ? t_adj[7:0] : sum;
        v_nx     = (a_r[7] ^ m_r[7]) & (a_r[7] ^ sum[7]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            m_r    <= '0;
            c_r    <= 1'b0;
            dec_r  <= 1'b0;
            al_r   <= '0;
            result <= '0;
            p_r    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                a_r   <= a;
                m_r   <= m;
                c_r   <= c_in;
                dec_r <= d_flag & DECIMAL_EN;
            end
            if (state == LO)
                al_r <= al;
            // Flags always come from the binary difference, even in decimal mode.
            if (state == HI) begin
                result <= res_nx;
                p_r    <= pack_flags(sum[7], v_nx, sum == 8'h00, cout);
            end
        end
    end

    assign c_out = flag_of(p_r, FLAG_C);
    assign v_out = flag_of(p_r, FLAG_V);
    assign z_out = flag_of(p_r, FLAG_Z);
    assign n_out = flag_of(p_r, FLAG_N);
endmodule

// File: tb/tb_sbc_unit.sv
// tb_sbc_unit: random and directed checks of sbc_unit (decimal on and off) against a behavioural model
module tb_sbc_unit;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, c_in = 1'b0, d_flag = 1'b0;
    logic [7:0] a = 8'h00, m = 8'h00;
    logic       busy_d, done_d, c_d, v_d, z_d, n_d;
    logic       busy_b, done_b, c_b, v_b, z_b, n_b;
    logic [7:0] result_d, result_b;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    sbc_unit #(.DECIMAL_EN(1'b1)) dut_d (
        .clk(clk), .rst(rst), .start(start), .a(a), .m(m), .c_in(c_in), .d_flag(d_flag),
        .busy(busy_d), .done(done_d), .result(result_d),
        .c_out(c_d), .v_out(v_d), .z_out(z_d), .n_out(n_d)
    );

    sbc_unit #(.DECIMAL_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .a(a), .m(m), .c_in(c_in), .d_flag(d_flag),
        .busy(busy_b), .done(done_b), .result(result_b),
        .c_out(c_b), .v_out(v_b), .z_out(z_b), .n_out(n_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer SBC: subtract with borrow, signed range test for V, NMOS decimal digits.
    function automatic void ref_sbc(input int av, input int mv, input int cv, input int dv,
                                    output int res, output int cf, output int vf,
                                    output int zf, output int nf);
        int diff, sa, sm, sd, al, t;
        diff = av - mv - (1 - cv);
        cf   = (diff >= 0) ? 1 : 0;
        res  = diff & 255;
        sa   = (av > 127) ? av - 256 : av;
        sm   = (mv > 127) ? mv - 256 : mv;
        sd   = sa - sm - (1 - cv);
        vf   = (sd < -128 || sd > 127) ? 1 : 0;
        zf   = (res == 0) ? 1 : 0;
        nf   = (res >= 128) ? 1 : 0;
        if (dv != 0) begin
            al = (av & 15) - (mv & 15) + cv - 1;
            if (al < 0) al = ((al - 6) & 15) - 16;
            t = (av & 240) - (mv & 240) + al;
            if (t < 0) t = t - 96;
            res = t & 255;
        end
    endfunction

    // Model: cycles since acceptance (0 = idle); results appear on the third edge after acceptance.
    int age = 0, la = 0, lm = 0, lc = 0, ld = 0;
    int er_d = 0, er_b = 0, ec = 0, ev = 0, ez = 0, en = 0;
    bit chk_en = 0;

    always @(posedge clk) begin
        int tc, tv, tz, tn;
        if (rst) begin
            age = 0; er_d = 0; er_b = 0; ec = 0; ev = 0; ez = 0; en = 0;
        end else if (age == 0) begin
            if (start) begin
                la = int'(a); lm = int'(m); lc = int'(c_in); ld = int'(d_flag); age = 1;
            end
        end else begin
            age = (age == 3) ? 0 : age + 1;
            if (age == 3) begin
                ref_sbc(la, lm, lc, ld, er_d, ec, ev, ez, en);
                ref_sbc(la, lm, lc, 0, er_b, tc, tv, tz, tn);
            end
        end
        chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_d", int'(busy_d), (age != 0) ? 1 : 0);
            chk("done_d", int'(done_d), (age == 3) ? 1 : 0);
            chk("result_d", int'(result_d), er_d);
            chk("c_d", int'(c_d), ec);
            chk("v_d", int'(v_d), ev);
            chk("z_d", int'(z_d), ez);
            chk("n_d", int'(n_d), en);
            chk("busy_b", int'(busy_b), (age != 0) ? 1 : 0);
            chk("done_b", int'(done_b), (age == 3) ? 1 : 0);
            chk("result_b", int'(result_b), er_b);
            chk("c_b", int'(c_b), ec);
            chk("v_b", int'(v_b), ev);
            chk("z_b", int'(z_b), ez);
            chk("n_b", int'(n_b), en);
        end
    end

    task automatic op(input int av, input int mv, input int cv, input int dv,
                      input int rd, input int rb, input int cf, input int vf,
                      input int zf, input int nf);
        int n;
        @(negedge clk);
        a = av[7:0]; m = mv[7:0]; c_in = cv[0]; d_flag = dv[0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hFF; m = 8'hFF;
        n = 1;
        while (!done_d && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("lit_latency", n, 3);
        chk("lit_res_d", int'(result_d), rd);
        chk("lit_res_b", int'(result_b), rb);
        chk("lit_c", int'(c_d), cf);
        chk("lit_v", int'(v_d), vf);
        chk("lit_z", int'(z_d), zf);
        chk("lit_n", int'(n_d), nf);
        @(negedge clk);
    endtask

    initial begin
        int dn;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", int'(result_d), 0);
        chk("rst_flags", int'({c_d, v_d, z_d, n_d, busy_d, done_d}), 0);
        rst = 1'b0;

        op(8'h50, 8'hB0, 1, 0, 8'hA0, 8'hA0, 0, 1, 0, 1);
        op(8'h05, 8'h05, 1, 0, 8'h00, 8'h00, 1, 0, 1, 0);
        op(8'h40, 8'h13, 1, 1, 8'h27, 8'h2D, 1, 0, 0, 0);
        op(8'h12, 8'h21, 1, 1, 8'h91, 8'hF1, 0, 0, 0, 1);
        op(8'h00, 8'h00, 0, 1, 8'h99, 8'hFF, 0, 0, 0, 1);

        // start held into LO must not launch a second operation
        @(negedge clk);
        a = 8'h33; m = 8'h11; c_in = 1'b1; d_flag = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h99;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (done_d) dn++;
            @(negedge clk);
        end
        chk("ovl_done_cnt", dn, 1);
        chk("ovl_result", int'(result_d), 8'h22);

        // reset while in HI discards the operation
        a = 8'h80; m = 8'h01; c_in = 1'b1; d_flag = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("hi_rst_busy", int'(busy_d), 0);
        chk("hi_rst_result", int'(result_d), 0);
        chk("hi_rst_flags", int'({c_d, v_d, z_d, n_d}), 0);
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done_d) dn++;
        end
        chk("hi_rst_no_done", dn, 0);

        repeat (400) begin
            @(negedge clk);
            a      = 8'($urandom);
            m      = 8'($urandom);
            c_in   = 1'($urandom_range(0, 1));
            d_flag = 1'($urandom_range(0, 1));
            start  = ($urandom_range(0, 2) != 0);
            rst    = ($urandom_range(0, 60) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (6) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
